// File: rtl/bus_sink_fifo.sv
// Keyed bus sink: captures matching bus words into a FWFT FIFO drained by valid/ready.
// Capture latency 1 cycle; a match into a full FIFO with no pop is dropped and flagged sticky overflow.
module bus_sink_fifo #(
    parameter int                      DATA_BUS_SIZE = 16,
    parameter int                      KEY_SIZE      = 8,
    parameter logic [KEY_SIZE-1:0]     LISTEN_CODE   = '0,
    parameter int                      DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_BUS_SIZE-1:0]   bus_data,
    input  logic [KEY_SIZE-1:0]        key,
    input  logic                       strobe,
    output logic                       ack,
    output logic [DATA_BUS_SIZE-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_BUS_SIZE-1:0] mem_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     ack_q, ack_d;
    logic                     ovf_q, ovf_d;

    logic match, pop, push;

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign ack       = ack_q;
    assign overflow  = ovf_q;

    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign match = strobe && (key == LISTEN_CODE);
    assign pop   = out_valid && out_ready;
    assign push  = match && ((count_q < CW'(DEPTH)) || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ack_d    = push;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        // Set beats clear when both happen in one cycle.
        if (match && !push)      ovf_d = 1'b1;
        else if (clear_overflow) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= bus_data;
    end

endmodule

// File: tb/tb_bus_sink_fifo.sv
// Bench for bus_sink_fifo: directed vector table, wrap-around sequence, and random traffic vs a queue model.
module tb_bus_sink_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_data;
    logic [7:0]  key;
    logic        strobe;
    logic        ack;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;
    logic        clear_overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_sink_fifo #(
        .DATA_BUS_SIZE(16), .KEY_SIZE(8), .LISTEN_CODE(8'h00), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .bus_data(bus_data), .key(key), .strobe(strobe),
        .ack(ack), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    // Reference model: plain queue plus flags.
    logic [15:0] mq[$];
    logic        m_ack;
    logic        m_ovf;

    task automatic model_step(input logic r, input logic s, input logic [7:0] k,
                              input logic [15:0] d, input logic rdy, input logic clr);
        bit m, p, pu;
        if (r) begin
            mq.delete();
            m_ack = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m  = s && (k == 8'h00);
            p  = (mq.size() > 0) && rdy;
            pu = m && ((mq.size() < 4) || p);
            if (p)  void'(mq.pop_front());
            if (pu) mq.push_back(d);
            m_ack = pu;
            if (m && !pu) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then sample 1ns later.
    task automatic cyc(input logic r, input logic s, input logic [7:0] k,
                       input logic [15:0] d, input logic rdy, input logic clr);
        rst = r; strobe = s; key = k; bus_data = d; out_ready = rdy; clear_overflow = clr;
        @(posedge clk);
        #1;
        model_step(r, s, k, d, rdy, clr);
    endtask

    typedef struct {
        logic        r, s;
        logic [7:0]  k;
        logic [15:0] d;
        logic        rdy, clr;
        logic        e_v;
        logic [15:0] e_d;
        logic [2:0]  e_c;
        logic        e_ack, e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic [7:0] k, logic [15:0] d, logic rdy,
                                logic clr, logic ev, logic [15:0] ed, logic [2:0] ec,
                                logic ea, logic eo);
        vec_t v;
        v.r = r; v.s = s; v.k = k; v.d = d; v.rdy = rdy; v.clr = clr;
        v.e_v = ev; v.e_d = ed; v.e_c = ec; v.e_ack = ea; v.e_ovf = eo;
        return v;
    endfunction

    task automatic add_fill();
        vecs.push_back(mk(0, 1, 8'h00, 16'h0001, 0, 0, 1, 16'h0001, 3'd1, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0002, 0, 0, 1, 16'h0001, 3'd2, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0003, 0, 0, 1, 16'h0001, 3'd3, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0004, 0, 0, 1, 16'h0001, 3'd4, 1, 0));
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; key = 8'h00; bus_data = '0; out_ready = 1'b0;
        clear_overflow = 1'b0;
        m_ack = 1'b0; m_ovf = 1'b0;

        // Reset, then idle with a non-matching strobe.
        vecs.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h0000, 3'd0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 8'h01, 16'h1234, 0, 0, 0, 16'h0000, 3'd0, 0, 0));
        // Single capture and pop.
        vecs.push_back(mk(0, 1, 8'h00, 16'hBEEF, 0, 0, 1, 16'hBEEF, 3'd1, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000, 3'd0, 0, 0));
        // Fill, overflow, drain.
        add_fill();
        vecs.push_back(mk(0, 1, 8'h00, 16'h0005, 0, 0, 1, 16'h0001, 3'd4, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'h0002, 3'd3, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'h0003, 3'd2, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'h0004, 3'd1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000, 3'd0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 1, 0, 16'h0000, 3'd0, 0, 0));
        // Full with simultaneous push and pop.
        add_fill();
        vecs.push_back(mk(0, 1, 8'h00, 16'h0009, 1, 0, 1, 16'h0002, 3'd4, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'h0003, 3'd3, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'h0004, 3'd2, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'h0009, 3'd1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000, 3'd0, 0, 0));
        // Key differing only in the MSB must not match.
        vecs.push_back(mk(0, 1, 8'h80, 16'h7777, 0, 0, 0, 16'h0000, 3'd0, 0, 0));
        // Overflow set-beats-clear, clear alone, then reset with entries held.
        add_fill();
        vecs.push_back(mk(0, 1, 8'h00, 16'h0005, 0, 0, 1, 16'h0001, 3'd4, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 16'h0006, 0, 1, 1, 16'h0001, 3'd4, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 1, 1, 16'h0001, 3'd4, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'h0002, 3'd3, 0, 0));
        vecs.push_back(mk(1, 1, 8'h00, 16'hAAAA, 1, 0, 0, 16'h0000, 3'd0, 0, 0));

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].s, vecs[i].k, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].e_v));
            check($sformatf("vec%0d.data", i),  32'(out_data),  32'(vecs[i].e_d));
            check($sformatf("vec%0d.count", i), 32'(count),     32'(vecs[i].e_c));
            check($sformatf("vec%0d.ack", i),   32'(ack),       32'(vecs[i].e_ack));
            check($sformatf("vec%0d.ovf", i),   32'(overflow),  32'(vecs[i].e_ovf));
        end

        // Wrap-around: ten back-to-back push/pop pairs.
        cyc(0, 1, 8'h00, 16'h0010, 0, 0);
        check("wrap.first", 32'(out_data), 32'h0010);
        for (int i = 1; i < 10; i++) begin
            cyc(0, 1, 8'h00, 16'(16'h0010 + i), 1, 0);
            check($sformatf("wrap%0d.data", i), 32'(out_data), 32'(16'h0010 + i));
            check($sformatf("wrap%0d.count", i), 32'(count), 32'd1);
            check($sformatf("wrap%0d.ack", i), 32'(ack), 32'd1);
        end
        cyc(0, 0, 8'h00, 16'h0000, 1, 0);
        check("wrap.empty", 32'(out_valid), 32'd0);

        // Random traffic against the model.
        cyc(1, 0, 8'h00, 16'h0000, 0, 0);
        for (int n = 0; n < 600; n++) begin
            logic       r, s, rdy, clr;
            logic [7:0] k;
            r   = ($urandom_range(0, 99) < 2);
            s   = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 4))
                0: k = 8'h80;
                1: k = 8'(1 << $urandom_range(0, 7));
                default: k = 8'h00;
            endcase
            rdy = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 99) < 10);
            cyc(r, s, k, 16'($urandom), rdy, clr);
            check("rnd.valid", 32'(out_valid), 32'(mq.size() > 0));
            check("rnd.data",  32'(out_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            check("rnd.count", 32'(count),     32'(mq.size()));
            check("rnd.ack",   32'(ack),       32'(m_ack));
            check("rnd.ovf",   32'(overflow),  32'(m_ovf));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_sink_fifo.md
Name: bus_sink_fifo

Overview:
- Receiving end of the keyed shared data bus.
- A producer drives a word onto the bus together with a destination key and a strobe. When the key equals this block's LISTEN_CODE, the block captures the word into a small FIFO.
- A local consumer drains the FIFO through a valid/ready handshake.
- Provides an ack to the bus side and a sticky overflow flag for words dropped while full.

Parameters:
- DATA_BUS_SIZE, 16, width of the bus data word and of the FIFO entries.
- KEY_SIZE, 8, width of the destination key.
- LISTEN_CODE, 8'h00 (KEY_SIZE bits), key value this sink responds to.
- DEPTH, 4, FIFO entries; a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_data  in  DATA_BUS_SIZE  shared bus data word.
- key  in  KEY_SIZE  destination key driven with bus_data.
- strobe  in  1  bus write strobe; a word is offered when high.
- ack  out  1  registered; high for one cycle, the cycle after a word was captured.
- out_data  out  DATA_BUS_SIZE  head of FIFO; 0 when out_valid=0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when high with out_valid.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a matching word was dropped.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset (rst=1 at edge):
  - Pointers, count, ack and overflow all go to 0.
  - out_valid=0 and out_data=0 from the next cycle.
  - FIFO contents are discarded.
  - Reset overrides every other input in the same cycle.
- Definitions:
  - match = strobe && (key == LISTEN_CODE), compared over all KEY_SIZE bits.
  - pop = out_valid && out_ready.
  - push = match && (count < DEPTH || pop).
  - A pop frees space in the same cycle, so a push into a full FIFO with a simultaneous pop succeeds.
- Push: bus_data is written at the write pointer; the write pointer advances modulo DEPTH.
  - Capture latency: a word pushed at edge N appears on out_data/out_valid after edge N when the FIFO was empty.
  - No combinational path from bus_data to out_data.
- Pop: the read pointer advances modulo DEPTH; out_data shows the next entry in the following cycle.
  - out_data is first-word-fall-through: it reflects mem[rd_ptr] while out_valid=1 and is forced to 0 otherwise.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
  - count never exceeds DEPTH and never wraps below 0.
- Pointer wrap:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Full/empty are derived from count only, not from pointer compare.
- ack <= push, every cycle.
  - Non-matching keys never produce ack and never change state.
  - strobe=0 ignores key and data.
- Overflow:
  - Set when match && !push, i.e. full with no pop.
  - Held until clear_overflow=1 at an edge.
  - If set and clear occur in the same cycle, set wins.
  - The dropped word is not stored; FIFO contents are unaffected.
- out_ready with out_valid=0 has no effect.
- Consecutive strobes on back-to-back cycles are each evaluated independently; the sustained rate is one word per cycle while space exists.
- Arithmetic is unsigned only; there is no data transformation.

Test Plan:
- Reset then idle: out_valid=0, out_data=0, count=0, ack=0, overflow=0 for 5 cycles, even with strobe=1 and key=8'h01 (non-matching).
- Single capture: key=8'h00, bus_data=16'hBEEF, strobe for 1 cycle -> next cycle ack=1, out_valid=1, out_data=16'hBEEF, count=1; out_ready=1 for 1 cycle -> out_valid=0, count=0.
- Fill and overflow: push 16'h0001..16'h0004 with out_ready=0 -> count=4, overflow=0; push 16'h0005 -> ack stays 0, overflow=1, count=4; drain reads 1,2,3,4 in order, 5 absent.
- Full with simultaneous push+pop: FIFO full holding 1..4; push 16'h0009 with out_ready=1 -> ack=1, count stays 4, overflow stays 0; drain order 2,3,4,9.
- Wrap-around: perform 10 push/pop pairs with values 16'h0010..16'h0019 at one cycle apart -> each value is output in order, and the pointers wrap twice without error.
- Overflow priority and reset mid-operation: with overflow=1 and FIFO full, assert clear_overflow together with a matching strobe -> overflow stays 1; then clear alone -> overflow=0; then rst with 3 entries held -> next cycle count=0, out_valid=0, out_data=0.
